// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and stream framing constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
      StWrite,
      StDone,
      StError
   } loader_state_e;

   localparam int unsigned HdrBytes  = 2;
   localparam int unsigned WordBytes = 4;

   // States in which the loader is waiting on the UART and the idle timeout runs.
   function automatic logic is_receiving(loader_state_e st);
      return (st == StLenLo) || (st == StLenHi) || (st == StData);
   endfunction

endpackage

// File: rtl/byte_to_word.sv
// Packs little-endian bytes into instruction words; lanes 0..2 are held, lane 3 passes straight through.
module byte_to_word
   import imem_loader_pkg::*;
#(
   parameter int unsigned NB_BYTE = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         valid_i,
   input  logic [NB_BYTE-1:0]           data_i,
   output logic [WordBytes*NB_BYTE-1:0] word_o,
   output logic                         complete_o
);

   localparam int unsigned LaneW = $clog2(WordBytes);
   localparam int unsigned BufW  = (WordBytes - 1) * NB_BYTE;

   logic [LaneW-1:0] lane_q, lane_d;
   logic [BufW-1:0]  buf_q, buf_d;

   assign complete_o = valid_i && (lane_q == LaneW'(WordBytes - 1));
   assign word_o     = {data_i, buf_q};

   // New bytes enter at the top so the first byte of a word ends up in the lowest lane.
   always_comb begin
      lane_d = lane_q;
      buf_d  = buf_q;
      if (clear_i) begin
         lane_d = '0;
         buf_d  = '0;
      end else if (valid_i) begin
         lane_d = lane_q + 1'b1;
         buf_d  = {data_i, buf_q[BufW-1:NB_BYTE]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= '0;
         buf_q  <= '0;
      end else begin
         lane_q <= lane_d;
         buf_q  <= buf_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word stream from a UART into instruction memory.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NB_BYTE    = 8,
   parameter int unsigned TIMEOUT    = 100000
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [NB_BYTE-1:0]    i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_wen,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int unsigned LenW     = HdrBytes * NB_BYTE;
   localparam int unsigned MaxWords = 1 << (ADDR_WIDTH - 2);
   localparam int unsigned CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   loader_state_e         state_q;
   logic [LenW-1:0]       len_q;
   logic [LenW-1:0]       idx_q;
   logic [CntW-1:0]       cnt_q;
   logic                  wen_q, busy_q, done_q, error_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic                         receiving, last_word, start_ok, timeout_hit;
   logic                         b2w_valid, word_done;
   logic [WordBytes*NB_BYTE-1:0] word;
   logic [LenW-1:0]              len_full;
   logic [LenW:0]                idx_inc;

   assign receiving = is_receiving(state_q);
   assign idx_inc   = {1'b0, idx_q} + 1'b1;
   assign last_word = (idx_inc == {1'b0, len_q});
   assign start_ok  = i_start && ((state_q == StIdle) || (state_q == StError));
   assign len_full  = {i_rx_data, len_q[NB_BYTE-1:0]};

   // A byte landing in the WRITE cycle is lane 0 of the next word, unless no next word exists.
   assign b2w_valid = i_rx_valid &&
                      ((state_q == StData) || ((state_q == StWrite) && !last_word));

   assign timeout_hit = (TIMEOUT != 0) && receiving && !i_rx_valid &&
                        (cnt_q == CntW'(TIMEOUT - 1));

   byte_to_word #(
      .NB_BYTE (NB_BYTE)
   ) u_byte_to_word (
      .clk_i      (clk),
      .rst_ni     (i_rst),
      .clear_i    (start_ok),
      .valid_i    (b2w_valid),
      .data_i     (i_rx_data),
      .word_o     (word),
      .complete_o (word_done)
   );

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= StIdle;
         len_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         wen_q  <= 1'b0;
         done_q <= 1'b0;

         if (receiving && !i_rx_valid && !timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end

         if (timeout_hit) begin
            state_q <= StError;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
         end else begin
            case (state_q)
               StIdle, StError: begin
                  if (i_start) begin
                     state_q <= StLenLo;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     error_q <= 1'b0;
                  end
               end
               StLenLo: begin
                  if (i_rx_valid) begin
                     len_q[NB_BYTE-1:0] <= i_rx_data;
                     state_q            <= StLenHi;
                  end
               end
               StLenHi: begin
                  if (i_rx_valid) begin
                     len_q <= len_full;
                     if (32'(len_full) > MaxWords) begin
                        state_q <= StError;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                     end else if (len_full == '0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= StData;
                     end
                  end
               end
               StData: begin
                  if (word_done) begin
                     state_q <= StWrite;
                     wen_q   <= 1'b1;
                     addr_q  <= ADDR_WIDTH'({idx_q, 2'b00});
                     wdata_q <= DATA_WIDTH'(word);
                  end
               end
               StWrite: begin
                  idx_q <= idx_inc[LenW-1:0];
                  if (last_word) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StData;
                  end
               end
               StDone: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_wen   = wen_q;
   assign o_addr  = addr_q;
   assign o_wdata = wdata_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_error = error_q;

endmodule
